// File: rtl/fetch_queue.sv
// Multi-lane fetch queue: circular buffer of {address, instr} with compacting WIDTH-lane enqueue/dequeue.
// Define FETCH_QUEUE_BYPASS_EN to forward input lanes straight to the outputs when the queue is empty and not stalled.
module fetch_queue #(
   parameter int XLEN  = 32,
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           in_valid,
   input  logic [WIDTH*XLEN-1:0]      in_address,
   input  logic [WIDTH*32-1:0]        in_instr,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out_valid,
   output logic [WIDTH*XLEN-1:0]      out_address,
   output logic [WIDTH*32-1:0]        out_instr,
   input  logic                       stop,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] r_addr  [DEPTH];
   logic [31:0]     r_instr [DEPTH];
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   logic [CW-1:0]   w_pos [WIDTH];
   logic [CW-1:0]   w_k;
   logic [CW-1:0]   w_d;
   logic [CW-1:0]   w_free;
   logic            w_byp;
   logic            w_enq;

   // Compaction slot of each valid input lane = number of valid lanes below it.
   always_comb begin
      w_k = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_pos[i] = w_k;
         if (in_valid[i]) w_k = w_k + CW'(1);
      end
   end

   assign w_free   = CW'(DEPTH) - r_count;
   assign in_ready = !reset && !flush && (w_free >= CW'(WIDTH));

`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_byp = !reset && !flush && !stop && (r_count == '0);
`else
   assign w_byp = 1'b0;
`endif

   assign w_enq = in_ready && !w_byp;
   assign w_d   = stop ? '0 : ((r_count < CW'(WIDTH)) ? r_count : CW'(WIDTH));
   assign count = r_count;

   always_comb begin
      out_valid   = '0;
      out_address = '0;
      out_instr   = '0;
      if (!reset) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CW'(i) < r_count) begin
               out_valid[i]                 = 1'b1;
               out_address[i*XLEN +: XLEN]  = r_addr[r_head + AW'(i)];
               out_instr[i*32 +: 32]        = r_instr[r_head + AW'(i)];
            end
         end
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      // Bypass only fires with the queue empty, so no stored lane is overwritten here.
      if (w_byp) begin
         for (int unsigned j = 0; j < WIDTH; j++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
               if (in_valid[i] && (w_pos[i] == CW'(j))) begin
                  out_valid[j]                = 1'b1;
                  out_address[j*XLEN +: XLEN] = in_address[i*XLEN +: XLEN];
                  out_instr[j*32 +: 32]       = in_instr[i*32 +: 32];
               end
            end
         end
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (w_enq) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_valid[i]) begin
               r_addr[r_tail + AW'(w_pos[i])]  <= in_address[i*XLEN +: XLEN];
               r_instr[r_tail + AW'(w_pos[i])] <= in_instr[i*32 +: 32];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + AW'(w_k);
         r_head  <= r_head + AW'(w_d);
         r_count <= r_count + (w_enq ? w_k : CW'(0)) - w_d;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (WIDTH=2, DEPTH=8); build with FETCH_QUEUE_BYPASS_EN to exercise the bypass path instead.
module tb_fetch_queue;
   localparam int XLEN  = 32;
   localparam int WIDTH = 2;
   localparam int DEPTH = 8;

   logic              clock = 1'b0;
   logic              reset, flush, stop;
   logic [WIDTH-1:0]  in_valid;
   logic [WIDTH*XLEN-1:0] in_address;
   logic [WIDTH*32-1:0]   in_instr;
   logic              in_ready;
   logic [WIDTH-1:0]  out_valid;
   logic [WIDTH*XLEN-1:0] out_address;
   logic [WIDTH*32-1:0]   out_instr;
   logic [3:0]        count;

   typedef struct {
      logic [31:0] a;
      logic [31:0] ins;
   } ent_t;
   ent_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b1;

   fetch_queue #(.XLEN(XLEN), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_address(in_address), .in_instr(in_instr),
      .in_ready(in_ready), .out_valid(out_valid), .out_address(out_address),
      .out_instr(out_instr), .stop(stop), .count(count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mk_instr(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
      in_valid   = v;
      in_address = {a1, a0};
      in_instr   = {mk_instr(a1), mk_instr(a0)};
   endtask

   // Drive one group for one cycle; expected acceptance is hand-supplied and scored entries are pushed in compacted order.
   task automatic enq(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1, input logic exp_rdy);
      ent_t e;
      drive(v, a0, a1);
      @(negedge clock);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (exp_rdy) begin
         if (v[0]) begin e.a = a0; e.ins = mk_instr(a0); exp_q.push_back(e); end
         if (v[1]) begin e.a = a1; e.ins = mk_instr(a1); exp_q.push_back(e); end
      end
      @(posedge clock); #1;
      in_valid = '0;
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   // Monitor: every presented lane consumed this cycle must match the scoreboard head; idle lanes must be zero.
   always @(negedge clock) begin
      if (mon_en && !reset && !flush && !stop) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (out_valid[i]) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL sb_unexpected: lane %0d addr 0x%0h presented, nothing expected", i, out_address[i*XLEN +: XLEN]);
               end else begin
                  ent_t e;
                  e = exp_q.pop_front();
                  chk("out_address", 64'(out_address[i*XLEN +: XLEN]), 64'(e.a));
                  chk("out_instr",   64'(out_instr[i*32 +: 32]),       64'(e.ins));
               end
            end else begin
               chk("idle_addr",  64'(out_address[i*XLEN +: XLEN]), 64'(0));
               chk("idle_instr", 64'(out_instr[i*32 +: 32]),       64'(0));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flush = 1'b0; stop = 1'b0;
      in_valid = '0; in_address = '0; in_instr = '0;
      tick();
      @(negedge clock);
      chk("rst_in_ready",  64'(in_ready),  64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_count",     64'(count),     64'(0));
      tick();
      reset = 1'b0;

`ifdef FETCH_QUEUE_BYPASS_EN
      mon_en = 1'b0;
      drive(2'b11, 32'h300, 32'h304);
      @(negedge clock);
      chk("byp_out_valid", 64'(out_valid), 64'(2'b11));
      chk("byp_addr0", 64'(out_address[31:0]),  64'(32'h300));
      chk("byp_addr1", 64'(out_address[63:32]), 64'(32'h304));
      chk("byp_in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = '0;
      @(negedge clock);
      chk("byp_count0", 64'(count), 64'(0));
      tick();
      stop = 1'b1;
      drive(2'b11, 32'h300, 32'h304);
      @(negedge clock);
      chk("byp_stall_out_valid", 64'(out_valid), 64'(0));
      tick();
      in_valid = '0;
      @(negedge clock);
      chk("byp_stall_count", 64'(count), 64'(2));
      chk("byp_stored_addr0", 64'(out_address[31:0]), 64'(32'h300));
      tick();
      stop = 1'b0;
      @(negedge clock);
      chk("byp_drain_valid", 64'(out_valid), 64'(2'b11));
      tick();
      @(negedge clock);
      chk("byp_drain_count", 64'(count), 64'(0));
      tick();
`else
      // Basic pair, one-cycle latency.
      enq(2'b11, 32'h100, 32'h104, 1'b1);
      @(negedge clock);
      chk("t1_out_valid", 64'(out_valid), 64'(2'b11));
      chk("t1_count",     64'(count),     64'(2));
      chk("t1_addr0",     64'(out_address[31:0]),  64'(32'h100));
      chk("t1_addr1",     64'(out_address[63:32]), 64'(32'h104));
      tick();
      @(negedge clock);
      chk("t1_count_after", 64'(count),     64'(0));
      chk("t1_empty_valid", 64'(out_valid), 64'(0));
      tick();

      // Upper lane only is compacted into lane 0.
      enq(2'b10, 32'hBAD, 32'h200, 1'b1);
      @(negedge clock);
      chk("t2_out_valid", 64'(out_valid), 64'(2'b01));
      chk("t2_addr0",     64'(out_address[31:0]), 64'(32'h200));
      chk("t2_count",     64'(count), 64'(1));
      tick();

      // Fill under stall (starting at index 3 so writes and reads straddle the wrap).
      stop = 1'b1;
      enq(2'b11, 32'h00, 32'h04, 1'b1);
      enq(2'b11, 32'h08, 32'h0C, 1'b1);
      enq(2'b11, 32'h10, 32'h14, 1'b1);
      @(negedge clock);
      chk("t3_count6",    64'(count),    64'(6));
      chk("t3_ready_at6", 64'(in_ready), 64'(1));
      tick();
      enq(2'b11, 32'h18, 32'h1C, 1'b1);
      @(negedge clock);
      chk("t3_count8",    64'(count),    64'(8));
      chk("t3_stall_addr0", 64'(out_address[31:0]), 64'(32'h00));
      tick();
      enq(2'b11, 32'h40, 32'h44, 1'b0);
      stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t3_drain_count", 64'(count), 64'(8 - 2*i));
         tick();
      end
      enq(2'b11, 32'h20, 32'h24, 1'b1);
      enq(2'b11, 32'h28, 32'h2C, 1'b1);
      enq(2'b11, 32'h30, 32'h34, 1'b1);
      @(negedge clock);
      chk("t3_stream_count", 64'(count), 64'(2));
      tick();
      @(negedge clock);
      chk("t3_stream_empty", 64'(count), 64'(0));
      tick();

      // Full boundary at DEPTH-WIDTH+1, refused even with a dequeue pending.
      stop = 1'b1;
      enq(2'b11, 32'h50, 32'h54, 1'b1);
      enq(2'b11, 32'h58, 32'h5C, 1'b1);
      enq(2'b11, 32'h60, 32'h64, 1'b1);
      enq(2'b01, 32'h68, 32'h6C, 1'b1);
      stop = 1'b0;
      enq(2'b11, 32'h70, 32'h74, 1'b0);

      // Flush at count 5 with a same-cycle input group.
      flush = 1'b1;
      drive(2'b11, 32'h80, 32'h84);
      @(negedge clock);
      chk("t4_count5",      64'(count),    64'(5));
      chk("t4_flush_ready", 64'(in_ready), 64'(0));
      tick();
      flush = 1'b0; in_valid = '0;
      exp_q.delete();
      @(negedge clock);
      chk("t4_flush_count", 64'(count),     64'(0));
      chk("t4_flush_valid", 64'(out_valid), 64'(0));
      tick();

      // Reset mid-fill overrides a pending enqueue.
      stop = 1'b1;
      enq(2'b11, 32'h90, 32'h94, 1'b1);
      enq(2'b11, 32'h98, 32'h9C, 1'b1);
      reset = 1'b1;
      drive(2'b11, 32'hA0, 32'hA4);
      @(negedge clock);
      chk("t5_rst_ready", 64'(in_ready),  64'(0));
      chk("t5_rst_valid", 64'(out_valid), 64'(0));
      tick();
      reset = 1'b0; in_valid = '0; stop = 1'b0;
      exp_q.delete();
      @(negedge clock);
      chk("t5_rst_count", 64'(count),     64'(0));
      chk("t5_rst_empty", 64'(out_valid), 64'(0));
      tick();
`endif

      chk("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, address width in bits.
REQ-002 Parameter WIDTH, default 2, lanes per cycle on both enqueue and dequeue sides; legal range 1..4.
REQ-003 Parameter DEPTH, default 8, entry count; power of two, at least 2*WIDTH.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  discards all stored entries (redirect or mispredict).
REQ-007 in_valid  in  WIDTH  per-lane valid from loader.
REQ-008 in_address  in  WIDTH*XLEN  lane i at bits [i*XLEN +: XLEN].
REQ-009 in_instr  in  WIDTH*32  lane i at bits [i*32 +: 32].
REQ-010 in_ready  out  1  queue accepts a full WIDTH-lane group this cycle.
REQ-011 out_valid  out  WIDTH  per-lane valid toward decoders.
REQ-012 out_address  out  WIDTH*XLEN  same lane packing as in_address.
REQ-013 out_instr  out  WIDTH*32  same lane packing as in_instr.
REQ-014 stop  in  1  downstream stall; when high, no entry is consumed.
REQ-015 count  out  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-016 Storage: circular buffer of DEPTH {address, instr} entries; head and tail pointers wrap modulo DEPTH.
REQ-017 in_ready = !reset && !flush && (DEPTH - count >= WIDTH); it ignores any same-cycle dequeue.
REQ-018 Enqueue happens when in_ready is high; valid lanes are compacted in ascending lane order and written at tail..tail+k-1, where k = popcount(in_valid).
REQ-019 When in_ready is low, in_valid is ignored and nothing is written; the loader holds its data.
REQ-020 out lane i presents the entry at head+i; out_valid[i] = (i < count).
REQ-021 Outputs are driven combinationally from registered storage.
REQ-022 Invalid out lanes drive all-zero address and instr.
REQ-023 Dequeue: when stop is low, all d = popcount(out_valid) presented entries are consumed at the edge; head advances by d.
REQ-024 When stop is high, d = 0 and outputs stay stable.
REQ-025 Simultaneous enqueue and dequeue: count_next = count + k - d.
REQ-026 Latency is one cycle: an entry written at edge t is presentable in the cycle after t.
REQ-027 Ordering is strict FIFO across lanes and across cycles; no entry is reordered, duplicated or dropped.
REQ-028 flush has priority over enqueue and dequeue: at the edge, head = tail = 0, count = 0, and same-cycle input is discarded.
REQ-029 Full boundary: with count = DEPTH-WIDTH+1, in_ready is 0 even when a dequeue is pending.
REQ-030 Empty boundary: with count = 0, out_valid = 0.
REQ-031 Wrap boundary: a k-lane write or a d-lane read crossing index DEPTH-1 continues at index 0.

Reset
REQ-032 At a clock edge with reset high: head = 0, tail = 0, count = 0; entry contents are don't-care.
REQ-033 While reset is high, in_ready = 0 and out_valid = 0, including when reset is asserted mid-operation with entries stored.
REQ-034 Reset overrides flush, enqueue and dequeue.

Configuration
REQ-035 Macro FETCH_QUEUE_BYPASS_EN, when defined: if count = 0, stop = 0, flush = 0 and reset = 0, valid input lanes drive the outputs in the same cycle (compacted) and are consumed without being stored, giving 0-cycle latency.
REQ-036 With FETCH_QUEUE_BYPASS_EN defined, whenever stop = 1 or count > 0, the normal store path applies.
REQ-037 When FETCH_QUEUE_BYPASS_EN is undefined, no combinational path exists from the in_* signals to the out_* signals.

Verification (WIDTH=2, DEPTH=8, bypass off unless stated)
REQ-038 Reset, then in_valid=2'b11 with addr 0x100/0x104 at stop=0 -> next cycle out_valid=2'b11, out_address lane0=0x100, lane1=0x104, count=2, then 0.
REQ-039 stop=1 while pushing 3 groups of 2 -> count=6, in_ready drops to 0 when count=7 is impossible, stays 1 at 6; push a 4th group -> count=8, in_ready=0.
REQ-040 Fill to 8 with addr 0x0..0x1C, release stop -> out pairs (0x0,0x4),(0x8,0xC),... in order; pointer wrap verified by 3 further groups.
REQ-041 in_valid=2'b10 with lane1 addr 0x200 -> stored as single entry; out_valid=2'b01, lane0 address=0x200.
REQ-042 count=5 with flush=1 and in_valid=2'b11 in the same cycle -> next cycle count=0, out_valid=0; reset mid-fill -> same result.
REQ-043 FETCH_QUEUE_BYPASS_EN defined, empty queue, in 0x300/0x304, stop=0 -> same-cycle out_valid=2'b11 and count stays 0; with stop=1 -> count=2.
